// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester and memory port bundle for mem_access_arbiter
interface mem_access_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_ack_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_ack_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_mem_ena;
  logic                  mem_wr_ena;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata,
    output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o,
    output mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena, busy_o
  );

  // Requester and memory side
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata,
    input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o,
    input  mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena, busy_o
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin fetch/data sequencer for one synchronous memory port
module mem_access_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_arbiter_if.slave   bus
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  generate
    if (RD_LATENCY < 1 || WR_LATENCY < 1) begin : g_bad_latency
      $error("mem_access_arbiter: RD_LATENCY and WR_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_gnt_d;
  logic          r_last_d;
  logic          r_we;

  logic w_any_req;
  logic w_gnt_d;

  assign w_any_req = bus.if_req_i | bus.d_req_i;
  // Data wins when alone, or in a conflict when fetch had the previous grant
  assign w_gnt_d   = bus.d_req_i & (~bus.if_req_i | ~r_last_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_gnt_d         <= 1'b0;
      r_last_d        <= 1'b0;
      r_we            <= 1'b0;
      bus.if_ack_o    <= 1'b0;
      bus.if_rdata_o  <= '0;
      bus.d_ack_o     <= 1'b0;
      bus.d_rdata_o   <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_mem_ena <= 1'b0;
      bus.mem_wr_ena  <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.if_ack_o <= 1'b0;
          bus.d_ack_o  <= 1'b0;
          if (w_any_req) begin
            r_gnt_d         <= w_gnt_d;
            r_last_d        <= w_gnt_d;
            r_we            <= w_gnt_d & bus.d_we_i;
            bus.mem_addr    <= w_gnt_d ? bus.d_addr_i : bus.if_addr_i;
            bus.mem_wdata   <= w_gnt_d ? bus.d_wdata_i : '0;
            bus.mem_mem_ena <= 1'b1;
            bus.mem_wr_ena  <= w_gnt_d & bus.d_we_i;
            r_cnt           <= (w_gnt_d && bus.d_we_i) ? CW'(WR_LATENCY) : CW'(RD_LATENCY);
            bus.busy_o      <= 1'b1;
            r_state         <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (!r_we) begin
              if (r_gnt_d) bus.d_rdata_o  <= bus.mem_rdata;
              else         bus.if_rdata_o <= bus.mem_rdata;
            end
            bus.mem_mem_ena <= 1'b0;
            bus.mem_wr_ena  <= 1'b0;
            bus.d_ack_o     <= r_gnt_d;
            bus.if_ack_o    <= ~r_gnt_d;
            r_state         <= S_ACK;
          end
        end
        S_ACK: begin
          bus.if_ack_o <= 1'b0;
          bus.d_ack_o  <= 1'b0;
          bus.busy_o   <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic saw_ack;

  mem_access_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  mem_access_arbiter #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .RD_LATENCY(2),
    .WR_LATENCY(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h3000: mem_word = 16'h1234;
      16'h3001: mem_word = 16'h0F0F;
      16'h3002: mem_word = 16'h5A5A;
      16'h0010: mem_word = 16'hAAAA;
      16'h0020: mem_word = 16'h5555;
      default:  mem_word = 16'hDEAD;
    endcase
  endfunction

  always_comb bus.mem_rdata = mem_word(bus.mem_addr);

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset with random inputs
    reset = 1'b1;
    bus.if_req_i  = 1'($urandom);
    bus.if_addr_i = 16'($urandom);
    bus.d_req_i   = 1'($urandom);
    bus.d_we_i    = 1'($urandom);
    bus.d_addr_i  = 16'($urandom);
    bus.d_wdata_i = 16'($urandom);
    cyc();
    cyc();
    check_eq("rst_busy",    16'(bus.busy_o), 16'h0);
    check_eq("rst_ena",     16'(bus.mem_mem_ena), 16'h0);
    check_eq("rst_wr",      16'(bus.mem_wr_ena), 16'h0);
    check_eq("rst_if_ack",  16'(bus.if_ack_o), 16'h0);
    check_eq("rst_d_ack",   16'(bus.d_ack_o), 16'h0);
    check_eq("rst_if_rd",   bus.if_rdata_o, 16'h0);
    check_eq("rst_d_rd",    bus.d_rdata_o, 16'h0);
    check_eq("rst_addr",    bus.mem_addr, 16'h0);
    check_eq("rst_wdata",   bus.mem_wdata, 16'h0);
    reset = 1'b0;
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    bus.d_we_i   = 1'b0;
    cyc();
    check_eq("idle_busy", 16'(bus.busy_o), 16'h0);

    // First conflict after reset: data first, then fetch
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 16'h0010;
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h3001;
    cyc();
    check_eq("c1_addr", bus.mem_addr, 16'h0010);
    check_eq("c1_ena",  16'(bus.mem_mem_ena), 16'h1);
    cyc();
    cyc();
    check_eq("c1_d_ack",  16'(bus.d_ack_o), 16'h1);
    check_eq("c1_if_ack", 16'(bus.if_ack_o), 16'h0);
    check_eq("c1_d_rd",   bus.d_rdata_o, 16'hAAAA);
    bus.d_req_i = 1'b0;
    cyc();
    check_eq("c1_idle_busy", 16'(bus.busy_o), 16'h0);
    cyc();
    check_eq("c1_f_addr", bus.mem_addr, 16'h3001);
    check_eq("c1_f_ena",  16'(bus.mem_mem_ena), 16'h1);
    cyc();
    cyc();
    check_eq("c1_f_ack", 16'(bus.if_ack_o), 16'h1);
    check_eq("c1_f_rd",  bus.if_rdata_o, 16'h0F0F);
    bus.if_req_i = 1'b0;
    cyc();

    // Second conflict: last grant was fetch, so data wins again
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 16'h0020;
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h3002;
    cyc();
    check_eq("c2_addr", bus.mem_addr, 16'h0020);
    cyc();
    cyc();
    check_eq("c2_d_ack", 16'(bus.d_ack_o), 16'h1);
    check_eq("c2_d_rd",  bus.d_rdata_o, 16'h5555);
    bus.d_req_i = 1'b0;
    cyc();
    cyc();
    check_eq("c2_f_addr", bus.mem_addr, 16'h3002);
    cyc();
    cyc();
    check_eq("c2_f_ack", 16'(bus.if_ack_o), 16'h1);
    check_eq("c2_f_rd",  bus.if_rdata_o, 16'h5A5A);
    bus.if_req_i = 1'b0;
    cyc();

    // Data write leaves d_rdata_o alone
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 16'h0040; bus.d_wdata_i = 16'hBEEF;
    cyc();
    check_eq("wr_wr_ena", 16'(bus.mem_wr_ena), 16'h1);
    check_eq("wr_ena",    16'(bus.mem_mem_ena), 16'h1);
    check_eq("wr_addr",   bus.mem_addr, 16'h0040);
    check_eq("wr_wdata",  bus.mem_wdata, 16'hBEEF);
    cyc();
    check_eq("wr_ack",     16'(bus.d_ack_o), 16'h1);
    check_eq("wr_wr_off",  16'(bus.mem_wr_ena), 16'h0);
    check_eq("wr_ena_off", 16'(bus.mem_mem_ena), 16'h0);
    check_eq("wr_d_rd",    bus.d_rdata_o, 16'h5555);
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    cyc();
    check_eq("wr_ack_pulse", 16'(bus.d_ack_o), 16'h0);

    // Single fetch
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h3000;
    cyc();
    check_eq("sf_ena1",  16'(bus.mem_mem_ena), 16'h1);
    check_eq("sf_addr1", bus.mem_addr, 16'h3000);
    check_eq("sf_wr1",   16'(bus.mem_wr_ena), 16'h0);
    cyc();
    check_eq("sf_ena2", 16'(bus.mem_mem_ena), 16'h1);
    check_eq("sf_ack2", 16'(bus.if_ack_o), 16'h0);
    cyc();
    check_eq("sf_ack3", 16'(bus.if_ack_o), 16'h1);
    check_eq("sf_ena3", 16'(bus.mem_mem_ena), 16'h0);
    check_eq("sf_rd",   bus.if_rdata_o, 16'h1234);
    bus.if_req_i = 1'b0;
    cyc();
    check_eq("sf_ack4", 16'(bus.if_ack_o), 16'h0);

    // Back-to-back fetches: acks at cycles 3, 7, 11
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h3000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq($sformatf("bb%0d_addr", k), bus.mem_addr, 16'h3000 + 16'(k));
      cyc();
      check_eq($sformatf("bb%0d_noack", k), 16'(bus.if_ack_o), 16'h0);
      cyc();
      check_eq($sformatf("bb%0d_ack", k), 16'(bus.if_ack_o), 16'h1);
      check_eq($sformatf("bb%0d_rd", k), bus.if_rdata_o,
               (k == 0) ? 16'h1234 : ((k == 1) ? 16'h0F0F : 16'h5A5A));
      if (k == 2) bus.if_req_i = 1'b0;
      else        bus.if_addr_i = 16'h3001 + 16'(k);
      cyc();
      check_eq($sformatf("bb%0d_idle", k), 16'(bus.busy_o), 16'h0);
    end

    // Reset during ACCESS cycle 1 aborts with no ack
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h3001;
    cyc();
    check_eq("ra_ena1", 16'(bus.mem_mem_ena), 16'h1);
    reset = 1'b1;
    bus.if_req_i = 1'b0;
    cyc();
    check_eq("ra_ena",  16'(bus.mem_mem_ena), 16'h0);
    check_eq("ra_busy", 16'(bus.busy_o), 16'h0);
    check_eq("ra_if_rd", bus.if_rdata_o, 16'h0);
    reset = 1'b0;
    saw_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      saw_ack = saw_ack | bus.if_ack_o | bus.d_ack_o;
    end
    check_eq("ra_no_ack", 16'(saw_ack), 16'h0);
    check_eq("ra_if_rd_hold", bus.if_rdata_o, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
